snake_game_ctrl: RTL and testbench

- Game sequencer for the VGA snake datapath.
- Generates the movement tick and accepts direction keys, rejecting 180° reversals.
- Counts apples into growth and score, and requests new apple coordinates from the random generator over a req/ack handshake.
- Runs the IDLE/INIT/PLAY/DEAD/WIN state machine. The snake body/render datapath consumes its outputs and returns collision levels.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_tick_gen.sv | 51 +++++
 rtl/snake_game_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game sequencer.
// Holds key codes, the game state encoding and the reversal filter.
package snake_pkg;

    localparam int unsigned CoordW  = 11;
    localparam int unsigned PeriodW = 26;

    typedef enum logic [2:0] {
        KeyD   = 3'd0,
        KeyS   = 3'd1,
        KeyA   = 3'd2,
        KeyW   = 3'd3,
        KeyRst = 3'd4
    } key_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StPlay = 3'd2,
        StDead = 3'd3,
        StWin  = 3'd4
    } state_e;

    typedef logic [1:0] dir_t;

    // d/a and s/w share bit 0 and differ in bit 1.
    function automatic logic is_opposite(input dir_t key, input dir_t cur);
        return (key[0] == cur[0]) && (key[1] != cur[1]);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement tick generator: the period shrinks with score down to a floor.
// Emits a combinational one-cycle tick when the counter reaches period-1.
module snake_tick_gen
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned SPEED_STEP = 100000,
    parameter int unsigned MIN_DIV    = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [6:0] score,
    output logic       tick
);

    localparam logic [PeriodW-1:0] TickDiv  = PeriodW'(TICK_DIV);
    localparam logic [PeriodW-1:0] Step     = PeriodW'(SPEED_STEP);
    localparam logic [PeriodW-1:0] MinDiv   = PeriodW'(MIN_DIV);
    localparam logic [PeriodW-1:0] Headroom =
        (TICK_DIV > MIN_DIV) ? PeriodW'(TICK_DIV - MIN_DIV) : '0;

    logic [PeriodW-1:0] reduction;
    logic [PeriodW-1:0] period;
    logic [PeriodW-1:0] cnt_q, cnt_d;

    // Clamp is decided before the subtraction so it can never wrap.
    always_comb begin
        reduction = PeriodW'(score) * Step;
        period    = (reduction >= Headroom) ? MinDiv : (TickDiv - reduction);
    end

    // >= keeps the counter safe when a score bump shortens the running period.
    assign tick = !clear && (cnt_q >= (period - PeriodW'(1)));

    always_comb begin
        cnt_d = cnt_q + PeriodW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: direction filter, move tick, apple scoring,
// apple request handshake and the IDLE/INIT/PLAY/DEAD/WIN state machine.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 5000000,
    parameter int unsigned SPEED_STEP      = 100000,
    parameter int unsigned MIN_DIV         = 1000000,
    parameter int unsigned APPLES_PER_GROW = 3,
    parameter int unsigned WIN_SCORE       = 30,
    parameter int unsigned APPLE_X0        = 40,
    parameter int unsigned APPLE_Y0        = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        key_dir,
    input  logic              key_valid,
    input  logic              hit_wall,
    input  logic              hit_self,
    input  logic              ate_apple,
    input  logic [CoordW-1:0] rand_x,
    input  logic [CoordW-1:0] rand_y,
    input  logic              apple_ack,
    output logic              apple_req,
    output logic [CoordW-1:0] apple_x,
    output logic [CoordW-1:0] apple_y,
    output logic              move_tick,
    output logic [1:0]        move_dir,
    output logic              grow,
    output logic              init_body,
    output logic [6:0]        score,
    output logic [2:0]        state
);

    localparam logic [CoordW-1:0] AppleX0  = CoordW'(APPLE_X0);
    localparam logic [CoordW-1:0] AppleY0  = CoordW'(APPLE_Y0);
    localparam logic [7:0]        LastCnt  = 8'(APPLES_PER_GROW - 1);
    localparam logic [7:0]        WinScore = 8'(WIN_SCORE);

    state_e            state_q, state_d;
    dir_t              pending_dir_q, pending_dir_d;
    dir_t              move_dir_q, move_dir_d;
    logic              move_tick_q, move_tick_d;
    logic              grow_q, grow_d;
    logic              init_body_q, init_body_d;
    logic              apple_req_q, apple_req_d;
    logic [CoordW-1:0] apple_x_q, apple_x_d;
    logic [CoordW-1:0] apple_y_q, apple_y_d;
    logic [6:0]        score_q, score_d;
    logic [7:0]        apple_cnt_q, apple_cnt_d;
    logic              armed_q, armed_d;

    logic       tick;
    logic       key_rst, key_move, hit, last_apple, eat_event;
    logic [7:0] score_inc;

    snake_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .SPEED_STEP (SPEED_STEP),
        .MIN_DIV    (MIN_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != StPlay),
        .score (score_q),
        .tick  (tick)
    );

    assign key_rst    = key_valid && (key_dir == KeyRst);
    assign key_move   = key_valid && !key_dir[2];
    assign hit        = hit_wall || hit_self;
    assign last_apple = (apple_cnt_q == LastCnt);
    assign score_inc  = {1'b0, score_q} + 8'd1;
    // An eat coinciding with a tick waits one cycle so grow never overlaps move_tick.
    assign eat_event  = (state_q == StPlay) && armed_q && !hit && ate_apple && !tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (key_move) state_d = StInit;
            StInit: state_d = StPlay;
            StPlay: begin
                if (armed_q && hit) begin
                    state_d = StDead;
                end else if (eat_event && last_apple && (score_inc == WinScore)) begin
                    state_d = StWin;
                end
            end
            default: state_d = state_q;
        endcase
        if (key_rst) begin
            state_d = StInit;
        end
    end

    always_comb begin
        pending_dir_d = pending_dir_q;
        move_dir_d    = move_dir_q;
        move_tick_d   = 1'b0;
        grow_d        = 1'b0;
        init_body_d   = 1'b0;
        apple_req_d   = apple_req_q;
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        score_d       = score_q;
        apple_cnt_d   = apple_cnt_q;
        armed_d       = armed_q;

        if (key_move) begin
            if (state_q == StIdle) begin
                pending_dir_d = key_dir[1:0];
                move_dir_d    = key_dir[1:0];
            end else if ((state_q == StPlay) && !is_opposite(key_dir[1:0], move_dir_q)) begin
                pending_dir_d = key_dir[1:0];
            end
        end

        if (apple_req_q && apple_ack) begin
            apple_x_d   = rand_x;
            apple_y_d   = rand_y;
            apple_req_d = 1'b0;
        end

        if ((state_q == StPlay) && armed_q && hit) begin
            armed_d = 1'b0;
        end else if (eat_event) begin
            armed_d = 1'b0;
            if (!apple_req_q) begin
                apple_req_d = 1'b1;
            end
            if (last_apple) begin
                apple_cnt_d = '0;
                grow_d      = 1'b1;
                score_d     = score_inc[6:0];
            end else begin
                apple_cnt_d = apple_cnt_q + 8'd1;
            end
        end

        if (tick && (state_d == StPlay)) begin
            move_tick_d = 1'b1;
            move_dir_d  = pending_dir_q;
            armed_d     = 1'b1;
        end

        if (state_d == StInit) begin
            init_body_d = 1'b1;
            move_tick_d = 1'b0;
            grow_d      = 1'b0;
            score_d     = '0;
            apple_cnt_d = '0;
            apple_x_d   = AppleX0;
            apple_y_d   = AppleY0;
            apple_req_d = 1'b0;
            armed_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_dir_q <= KeyD[1:0];
            move_dir_q    <= KeyD[1:0];
            move_tick_q   <= 1'b0;
            grow_q        <= 1'b0;
            init_body_q   <= 1'b0;
            apple_req_q   <= 1'b0;
            apple_x_q     <= AppleX0;
            apple_y_q     <= AppleY0;
            score_q       <= '0;
            apple_cnt_q   <= '0;
            armed_q       <= 1'b0;
        end else begin
            pending_dir_q <= pending_dir_d;
            move_dir_q    <= move_dir_d;
            move_tick_q   <= move_tick_d;
            grow_q        <= grow_d;
            init_body_q   <= init_body_d;
            apple_req_q   <= apple_req_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            score_q       <= score_d;
            apple_cnt_q   <= apple_cnt_d;
            armed_q       <= armed_d;
        end
    end

    assign apple_req = apple_req_q;
    assign apple_x   = apple_x_q;
    assign apple_y   = apple_y_q;
    assign move_tick = move_tick_q;
    assign move_dir  = move_dir_q;
    assign grow      = grow_q;
    assign init_body = init_body_q;
    assign score     = score_q;
    assign state     = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with short tick periods.
// Instance a follows the main sequence; instance b exercises the period floor.
module tb_snake_game_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  key_dir;
    logic        key_valid, hit_wall, hit_self, ate_apple, apple_ack;
    logic [10:0] rand_x, rand_y;
    logic        apple_req, move_tick, grow, init_body;
    logic [10:0] apple_x, apple_y;
    logic [1:0]  move_dir;
    logic [6:0]  score;
    logic [2:0]  state;

    logic [2:0]  key_dir_b;
    logic        key_valid_b, ate_b;
    logic        apple_req_b, move_tick_b, grow_b, init_body_b;
    logic [10:0] apple_x_b, apple_y_b;
    logic [1:0]  move_dir_b;
    logic [6:0]  score_b;
    logic [2:0]  state_b;

    int tests;
    int failed;
    int n;
    int g;

    snake_game_ctrl #(
        .TICK_DIV(10), .SPEED_STEP(1), .MIN_DIV(4), .APPLES_PER_GROW(3),
        .WIN_SCORE(2), .APPLE_X0(40), .APPLE_Y0(40)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_dir(key_dir), .key_valid(key_valid),
        .hit_wall(hit_wall), .hit_self(hit_self), .ate_apple(ate_apple),
        .rand_x(rand_x), .rand_y(rand_y), .apple_ack(apple_ack),
        .apple_req(apple_req), .apple_x(apple_x), .apple_y(apple_y),
        .move_tick(move_tick), .move_dir(move_dir), .grow(grow),
        .init_body(init_body), .score(score), .state(state)
    );

    snake_game_ctrl #(
        .TICK_DIV(10), .SPEED_STEP(4), .MIN_DIV(4), .APPLES_PER_GROW(3),
        .WIN_SCORE(30), .APPLE_X0(40), .APPLE_Y0(40)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .key_dir(key_dir_b), .key_valid(key_valid_b),
        .hit_wall(1'b0), .hit_self(1'b0), .ate_apple(ate_b),
        .rand_x(11'd7), .rand_y(11'd9), .apple_ack(apple_req_b),
        .apple_req(apple_req_b), .apple_x(apple_x_b), .apple_y(apple_y_b),
        .move_tick(move_tick_b), .move_dir(move_dir_b), .grow(grow_b),
        .init_body(init_body_b), .score(score_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles until the next move_tick, at least one step; returns limit on timeout.
    task automatic wait_tick(input int limit, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (move_tick !== 1'b1 && cyc < limit);
    endtask

    task automatic wait_tick_b(input int limit, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (move_tick_b !== 1'b1 && cyc < limit);
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            step();
            if (move_tick === 1'b1) cnt++;
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        rst_n = 1'b0;
        key_dir = 3'd0; key_valid = 1'b0; hit_wall = 1'b0; hit_self = 1'b0;
        ate_apple = 1'b0; apple_ack = 1'b0; rand_x = '0; rand_y = '0;
        key_dir_b = 3'd0; key_valid_b = 1'b0; ate_b = 1'b0;

        repeat (3) step();
        check("rst_state", 32'(state), 0);
        check("rst_apple_x", 32'(apple_x), 40);
        check("rst_apple_y", 32'(apple_y), 40);
        check("rst_score", 32'(score), 0);
        check("rst_move_dir", 32'(move_dir), 0);
        check("rst_apple_req", 32'(apple_req), 0);
        check("rst_pulses", {29'd0, move_tick, grow, init_body}, 0);
        rst_n = 1'b1;

        count_ticks(20, n);
        check("idle_no_tick", n, 0);
        check("idle_state", 32'(state), 0);

        key_valid = 1'b1; key_dir = 3'd3;
        step();
        key_valid = 1'b0;
        check("init_state", 32'(state), 1);
        check("init_pulse", 32'(init_body), 1);
        check("init_move_dir", 32'(move_dir), 3);
        step();
        check("play_state", 32'(state), 2);
        check("init_pulse_end", 32'(init_body), 0);

        for (int i = 0; i < 5; i++) begin
            wait_tick(40, n);
            check("tick_period", n, 10);
            check("tick_dir_w", 32'(move_dir), 3);
        end

        // s is a reversal of w and must be dropped; a then wins.
        key_valid = 1'b1; key_dir = 3'd1;
        step();
        key_dir = 3'd2;
        step();
        key_valid = 1'b0;
        check("dir_hold", 32'(move_dir), 3);
        wait_tick(40, n);
        check("dir_tick_gap", n, 8);
        check("dir_a", 32'(move_dir), 2);

        key_valid = 1'b1; key_dir = 3'd0;
        step();
        key_valid = 1'b0;
        wait_tick(40, n);
        check("dir_rev_gap", n, 9);
        check("dir_rev_drop", 32'(move_dir), 2);

        for (int e = 0; e < 3; e++) begin
            ate_apple = 1'b1;
            step();
            check("eat_req", 32'(apple_req), 1);
            check("grow_latency", 32'(grow), (e == 2) ? 1 : 0);
            g = grow ? 1 : 0;
            repeat (4) begin
                step();
                if (grow) g++;
            end
            ate_apple = 1'b0;
            check("grow_count", g, (e == 2) ? 1 : 0);
            check("eat_score", 32'(score), (e == 2) ? 1 : 0);
            wait_tick(40, n);
            check("eat_tick_gap", n, (e == 2) ? 4 : 5);
        end
        wait_tick(40, n);
        check("period_score1", n, 9);

        rand_x = 11'd220; rand_y = 11'd140;
        repeat (7) step();
        check("req_held", 32'(apple_req), 1);
        apple_ack = 1'b1;
        step();
        apple_ack = 1'b0;
        check("ack_x", 32'(apple_x), 220);
        check("ack_y", 32'(apple_y), 140);
        check("ack_req_low", 32'(apple_req), 0);
        rand_x = 11'd5; rand_y = 11'd6;
        apple_ack = 1'b1;
        step();
        apple_ack = 1'b0;
        check("stray_ack_x", 32'(apple_x), 220);

        wait_tick(40, n);
        hit_wall = 1'b1; ate_apple = 1'b1;
        step();
        hit_wall = 1'b0; ate_apple = 1'b0;
        check("dead_state", 32'(state), 3);
        check("dead_no_grow", 32'(grow), 0);
        check("dead_score", 32'(score), 1);
        check("dead_no_req", 32'(apple_req), 0);
        count_ticks(20, n);
        check("dead_no_tick", n, 0);
        check("dead_stays", 32'(state), 3);

        key_valid = 1'b1; key_dir = 3'd4;
        step();
        key_valid = 1'b0;
        check("rst_key_state", 32'(state), 1);
        check("rst_key_init", 32'(init_body), 1);
        check("rst_key_score", 32'(score), 0);
        check("rst_key_x", 32'(apple_x), 40);
        check("rst_key_y", 32'(apple_y), 40);
        step();

        // Code 5 would map onto s if its upper bit were ignored.
        key_valid = 1'b1; key_dir = 3'd5;
        step();
        key_valid = 1'b0;
        wait_tick(40, n);
        check("replay_gap", n, 9);
        check("key5_ignored", 32'(move_dir), 2);

        for (int i = 0; i < 6; i++) begin
            ate_apple = 1'b1;
            step();
            ate_apple = 1'b0;
            if (i < 5) wait_tick(40, n);
        end
        check("win_state", 32'(state), 4);
        check("win_score", 32'(score), 2);
        check("win_grow", 32'(grow), 1);
        count_ticks(30, n);
        check("win_no_tick", n, 0);
        check("win_req_held", 32'(apple_req), 1);
        rand_x = 11'd300; rand_y = 11'd301;
        apple_ack = 1'b1;
        step();
        apple_ack = 1'b0;
        check("win_ack_x", 32'(apple_x), 300);
        check("win_ack_y", 32'(apple_y), 301);
        check("win_ack_req", 32'(apple_req), 0);

        key_valid_b = 1'b1; key_dir_b = 3'd0;
        step();
        key_valid_b = 1'b0;
        check("b_init", 32'(state_b), 1);
        step();
        check("b_play", 32'(state_b), 2);
        for (int i = 0; i < 6; i++) begin
            wait_tick_b(40, n);
            ate_b = 1'b1;
            step();
            ate_b = 1'b0;
        end
        check("b_score", 32'(score_b), 2);
        wait_tick_b(40, n);
        wait_tick_b(40, n);
        check("b_period_floor", n, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
